// File: rtl/simframe_check_if.sv
// simframe_check_if: AXI-Stream bundle from the frame generator into the checker.
interface simframe_check_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/simframe_check.sv
// simframe_check: passive checker of replicated-pattern frames against frame geometry.
// Define SIMFRAME_CHECK_SEQ_EN to also require each frame pattern to be the previous + 1.
module simframe_check #(
  parameter int PATTERN_WIDTH = 32,
  parameter int DATA_WIDTH    = 512
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [15:0]              CYCLES_PER_PKT,
  input  logic [15:0]              PKTS_PER_FRAME,
  input  logic                     clear,
  simframe_check_if.slave          axis_in,
  output logic [31:0]              frame_count,
  output logic [31:0]              data_err_count,
  output logic [31:0]              tlast_err_count,
  output logic [31:0]              seq_err_count,
  output logic [PATTERN_WIDTH-1:0] frame_pattern,
  output logic                     frame_done,
  output logic                     frame_ok
);
  localparam int LANES = DATA_WIDTH / PATTERN_WIDTH;
  typedef enum logic {IDLE, FRAME} state_t;
  state_t                   state, state_d;
  logic [PATTERN_WIDTH-1:0] pattern_q, pattern_c;
  logic [15:0]              cyc_q, pkt_q, cyc_lim_q, pkt_lim_q;
  logic [15:0]              cyc_c, pkt_c, cyc_lim_c, pkt_lim_c;
  logic                     err_q, err_c, start, beat;
  logic                     data_err, tlast_err, seq_err, cyc_wrap, frame_end;
  logic [LANES-1:0]         lane_mis;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
  assign axis_in.tready = resetn;
  // a beat coinciding with clear is dropped entirely
  assign beat = axis_in.tvalid & resetn & ~clear;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_mis[g] = axis_in.tdata[g*PATTERN_WIDTH +: PATTERN_WIDTH] != pattern_c;
  end
  // in IDLE the current beat is checked against freshly captured frame parameters
  always_comb begin
    start     = state == IDLE;
    pattern_c = start ? axis_in.tdata[PATTERN_WIDTH-1:0] : pattern_q;
    cyc_lim_c = start ? ((CYCLES_PER_PKT == 16'd0) ? 16'd0 : CYCLES_PER_PKT - 16'd1) : cyc_lim_q;
    pkt_lim_c = start ? ((PKTS_PER_FRAME == 16'd0) ? 16'd0 : PKTS_PER_FRAME - 16'd1) : pkt_lim_q;
    cyc_c     = start ? 16'd0 : cyc_q;
    pkt_c     = start ? 16'd0 : pkt_q;
    cyc_wrap  = cyc_c == cyc_lim_c;
    data_err  = |lane_mis;
    tlast_err = axis_in.tlast != cyc_wrap;
    err_c     = (~start & err_q) | data_err | tlast_err | seq_err;
    frame_end = beat & cyc_wrap & (pkt_c == pkt_lim_c);
    state_d   = frame_end ? IDLE : beat ? FRAME : state;
  end
  always_ff @(posedge clk) begin
    if (!resetn || clear) state <= IDLE;
    else                  state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      pattern_q       <= '0;
      cyc_q           <= '0;
      pkt_q           <= '0;
      cyc_lim_q       <= '0;
      pkt_lim_q       <= '0;
      err_q           <= 1'b0;
      frame_count     <= '0;
      data_err_count  <= '0;
      tlast_err_count <= '0;
      frame_pattern   <= '0;
      frame_done      <= 1'b0;
      frame_ok        <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (beat) begin
        pattern_q <= pattern_c;
        cyc_lim_q <= cyc_lim_c;
        pkt_lim_q <= pkt_lim_c;
        err_q     <= err_c;
        cyc_q     <= cyc_wrap ? 16'd0 : cyc_c + 16'd1;
        pkt_q     <= cyc_wrap ? pkt_c + 16'd1 : pkt_c;
        if (data_err)  data_err_count  <= sat_inc(data_err_count);
        if (tlast_err) tlast_err_count <= sat_inc(tlast_err_count);
      end
      if (frame_end) begin
        frame_count   <= sat_inc(frame_count);
        frame_pattern <= pattern_c;
        frame_ok      <= ~err_c;
      end
    end
  end
`ifdef SIMFRAME_CHECK_SEQ_EN
  logic [PATTERN_WIDTH-1:0] prev_q;
  logic                     have_prev_q;
  assign seq_err = start & have_prev_q &
                   (axis_in.tdata[PATTERN_WIDTH-1:0] != prev_q + PATTERN_WIDTH'(1));
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      seq_err_count <= '0;
    end else if (beat && start) begin
      prev_q      <= axis_in.tdata[PATTERN_WIDTH-1:0];
      have_prev_q <= 1'b1;
      if (seq_err) seq_err_count <= sat_inc(seq_err_count);
    end
  end
`else
  assign seq_err       = 1'b0;
  assign seq_err_count = '0;
`endif
endmodule

// File: tb/tb_simframe_check.sv
// tb_simframe_check: directed stimulus with a frame-level reference model.
module tb_simframe_check;
  localparam int PW = 32;
  localparam int DW = 512;
  localparam int LN = DW / PW;
  logic clk = 0, resetn = 0, clear = 0;
  logic [15:0] cpp = 16'd4, ppf = 16'd3;
  logic [31:0] frame_count, data_err_count, tlast_err_count, seq_err_count;
  logic [PW-1:0] frame_pattern;
  logic frame_done, frame_ok;
  int checks = 0, errors = 0, cyc = 0, done_n = 0;
  bit started = 0;
  int done_cyc[$];
  bit ok_q[$];
  simframe_check_if #(.DATA_WIDTH(DW)) axis ();
  simframe_check #(.PATTERN_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .CYCLES_PER_PKT(cpp), .PKTS_PER_FRAME(ppf),
    .clear(clear), .axis_in(axis), .frame_count(frame_count),
    .data_err_count(data_err_count), .tlast_err_count(tlast_err_count),
    .seq_err_count(seq_err_count), .frame_pattern(frame_pattern),
    .frame_done(frame_done), .frame_ok(frame_ok));
  always #5 clk = ~clk;
  // reference model: frame position as a single beat index within cycles*packets
  int m_fc, m_de, m_te, m_se, m_pos, m_cn, m_pn;
  logic [31:0] m_pat, m_prev, m_fpat;
  bit m_in, m_have, m_done, m_ok, m_ferr;
  always @(posedge clk) begin
    cyc++;
    if (!resetn || clear) begin
      m_fc = 0; m_de = 0; m_te = 0; m_se = 0; m_in = 0; m_have = 0;
      m_done = 0; m_ok = 0; m_fpat = 0;
    end else begin
      m_done = 0;
      if (axis.tvalid) begin
        bit bad;
        if (!m_in) begin
          m_pat = axis.tdata[31:0];
          m_cn = (cpp == 0) ? 1 : int'(cpp);
          m_pn = (ppf == 0) ? 1 : int'(ppf);
          m_pos = 0; m_ferr = 0; m_in = 1;
`ifdef SIMFRAME_CHECK_SEQ_EN
          if (m_have && m_pat != m_prev + 32'd1) begin m_se++; m_ferr = 1; end
`endif
          m_prev = m_pat; m_have = 1;
        end
        bad = 0;
        for (int l = 0; l < LN; l++) if (axis.tdata[l*PW +: PW] != m_pat) bad = 1;
        if (bad) begin m_de++; m_ferr = 1; end
        if (axis.tlast != ((m_pos % m_cn) == m_cn - 1)) begin m_te++; m_ferr = 1; end
        if (m_pos == m_cn * m_pn - 1) begin
          m_fc++; m_fpat = m_pat; m_done = 1; m_ok = !m_ferr; m_in = 0;
        end else m_pos++;
      end
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    check("tready", 64'(axis.tready), 64'(resetn));
    check("frame_count", 64'(frame_count), 64'(m_fc));
    check("data_err_count", 64'(data_err_count), 64'(m_de));
    check("tlast_err_count", 64'(tlast_err_count), 64'(m_te));
    check("seq_err_count", 64'(seq_err_count), 64'(m_se));
    check("frame_pattern", 64'(frame_pattern), 64'(m_fpat));
    check("frame_done", 64'(frame_done), 64'(m_done));
    if (m_done) check("frame_ok", 64'(frame_ok), 64'(m_ok));
    if (frame_done) begin done_n++; done_cyc.push_back(cyc); ok_q.push_back(frame_ok); end
  end
  task automatic drive(input logic [31:0] pat, input bit last, input bit clr = 0);
    @(posedge clk); #1;
    axis.tvalid = 1; axis.tdata = {LN{pat}}; axis.tlast = last; clear = clr;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; axis.tvalid = 0; axis.tlast = 0; clear = 0; end
  endtask
  task automatic do_clear();
    @(posedge clk); #1; axis.tvalid = 0; clear = 1;
    @(posedge clk); #1; clear = 0;
    done_n = 0; done_cyc.delete(); ok_q.delete();
  endtask
  task automatic frame(input logic [31:0] pat);
    for (int i = 0; i < 12; i++) drive(pat, (i % 4) == 3);
  endtask
  initial begin
    int gap;
    axis.tvalid = 0; axis.tlast = 0; axis.tdata = '0;
    @(posedge clk); #1; started = 1;
    check("reset_tready", 64'(axis.tready), 0);
    check("reset_frame_count", 64'(frame_count), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    // two clean 4x3 frames back to back
    frame(32'h1); frame(32'h2); idle(2);
    check("t1_frames", 64'(frame_count), 2);
    check("t1_pattern", 64'(frame_pattern), 64'h2);
    check("t1_done_pulses", 64'(done_n), 2);
    gap = (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1;
    check("t1_done_gap", 64'(gap), 12);
    check("t1_ok_both", 64'((ok_q.size() == 2) && ok_q[0] && ok_q[1]), 1);
    check("t1_errs", 64'(data_err_count | tlast_err_count | seq_err_count), 0);
    // lane 7 of beat 5 corrupted
    do_clear();
    for (int i = 0; i < 12; i++) begin
      drive(32'h3, (i % 4) == 3);
      if (i == 5) axis.tdata[7*PW +: PW] = 32'hDEADBEEF;
    end
    frame(32'h4); idle(2);
    check("t2_data_err", 64'(data_err_count), 1);
    check("t2_ok_pair", 64'((ok_q.size() == 2) ? {ok_q[0], ok_q[1]} : 2'b11), 64'b01);
    // TLAST on beat 2 instead of 3
    do_clear();
    for (int i = 0; i < 12; i++) drive(32'h7, (i == 2) || (i % 4 == 3 && i != 3));
    idle(2);
    check("t3_tlast_err", 64'(tlast_err_count), 2);
    check("t3_frames", 64'(frame_count), 1);
    // 0x0 geometry: every beat is a frame, random gaps
    cpp = 0; ppf = 0;
    do_clear();
    for (int i = 0; i < 100; i++) begin
      drive(32'(i), 1);
      if ($urandom_range(1) == 1) idle(1 + $urandom_range(2));
    end
    idle(2);
    check("t4_frames", 64'(frame_count), 100);
    check("t4_done_pulses", 64'(done_n), 100);
    check("t4_tlast_err", 64'(tlast_err_count), 0);
    // clear on beat 7 abandons the frame
    cpp = 4; ppf = 3;
    do_clear();
    for (int i = 0; i < 8; i++) drive(32'h9, (i % 4) == 3, i == 7);
    idle(1);
    frame(32'hA); idle(2);
    check("t5_frames", 64'(frame_count), 1);
    check("t5_errs", 64'(data_err_count | tlast_err_count | seq_err_count), 0);
    check("t5_pattern", 64'(frame_pattern), 64'hA);
    // pattern sequence with wrap
    cpp = 1; ppf = 1;
    do_clear();
    drive(32'hFFFF_FFFF, 1); drive(32'h0, 1); drive(32'h5, 1); idle(2);
    check("t6_frames", 64'(frame_count), 3);
`ifdef SIMFRAME_CHECK_SEQ_EN
    check("t6_seq_err", 64'(seq_err_count), 1);
    check("t6_ok_last", 64'((ok_q.size() == 3) ? {ok_q[0], ok_q[1], ok_q[2]} : 3'b111), 64'b110);
`else
    check("t6_seq_err", 64'(seq_err_count), 0);
    check("t6_ok_last", 64'((ok_q.size() == 3) ? {ok_q[0], ok_q[1], ok_q[2]} : 3'b000), 64'b111);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
